// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM burst reader: FSM states and the fixed
// depth/latency constants that size the read-issue credit loop.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

  // Output buffer depth: the 3-cycle round trip from issue to visibility plus one
  // entry of slack lets the reader sustain one word per cycle.
  localparam int FIFO_DEPTH = 4;

  // Cycles from the read address being driven until the RAM data is capturable.
  localparam int READ_LATENCY = 2;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO with an occupancy count. The head entry is always
// presented on pop_data; a simultaneous push and pop leaves the count unchanged.
module stream_skid_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // A full FIFO refuses writes and an empty one refuses reads, so the pointers
  // can never run past each other even if a caller misbehaves.
  assign push_ok  = push && (count != CW'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; entries clear on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Walks a burst of consecutive RAM addresses and turns the RAM's fixed 2-cycle
// read latency into a valid/ready word stream that tolerates backpressure.
// Optional feature: define RAM_BURST_READER_CHECKSUM_EN to add out_checksum,
// the running sum of words transferred in the current burst.
module ram_burst_reader
  import ram_reader_pkg::*;
#(
  parameter int p_addresswidth = 4,
  parameter int p_datawidth    = 16
) (
  input  logic                      inclk,
  input  logic                      inrst_n,
  input  logic                      in_start,
  input  logic [p_addresswidth-1:0] in_startaddr,
  input  logic [p_addresswidth:0]   in_length,
  output logic [p_addresswidth-1:0] out_rdaddress,
  input  logic [p_datawidth-1:0]    in_rddata,
  output logic [p_datawidth-1:0]    out_data,
  output logic                      out_valid,
  input  logic                      in_ready,
`ifdef RAM_BURST_READER_CHECKSUM_EN
  output logic [p_datawidth-1:0]    out_checksum,
`endif
  output logic                      out_busy,
  output logic                      out_done
);

  localparam int CW    = $clog2(FIFO_DEPTH+1);
  localparam int OUT_W = $clog2(FIFO_DEPTH+READ_LATENCY+1);

  reader_state_t               state;
  reader_state_t               state_next;
  logic [p_addresswidth:0]     remaining;
  logic [READ_LATENCY-1:0]     pipe;
  logic [CW-1:0]               fifo_count;
  logic [OUT_W-1:0]            outstanding;
  logic                        accept;
  logic                        issue;
  logic                        last_issue;
  logic                        pop;
  logic                        drain_empty;

  // A new burst is taken whenever no burst is running, including the done cycle.
  assign accept     = in_start && ((state == IDLE) || (state == DONE));
  assign issue      = (state == READ) && (outstanding < OUT_W'(FIFO_DEPTH));
  assign last_issue = issue && (remaining == (p_addresswidth+1)'(1));
  assign pop        = out_valid && in_ready;
  assign out_valid  = (fifo_count != '0);
  assign out_busy   = (state == READ) || (state == DRAIN);
  assign out_done   = (state == DONE);

  // The drain finishes in the cycle the last buffered word is handed over, so
  // the done pulse lands immediately after the final transfer.
  assign drain_empty = (pipe == '0) &&
                       ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  // Issue credit: words already buffered plus reads still travelling through the RAM.
  always_comb begin
    outstanding = OUT_W'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding = outstanding + OUT_W'(pipe[i]);
    end
  end

  // Next-state logic; an empty burst goes through one drain cycle with nothing
  // outstanding so it shows the same busy-then-done shape as any other burst.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = (in_length == '0) ? DRAIN : READ;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address counter and remaining-word count; the address wraps naturally at its width.
  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      out_rdaddress <= '0;
      remaining     <= '0;
    end else if (accept) begin
      out_rdaddress <= in_startaddr;
      remaining     <= in_length;
    end else if (issue) begin
      out_rdaddress <= out_rdaddress + p_addresswidth'(1);
      remaining     <= remaining - (p_addresswidth+1)'(1);
    end
  end

  // Valid pipe that tracks each issued read until its data appears on in_rddata.
  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[READ_LATENCY-2:0], issue};
    end
  end

  stream_skid_fifo #(
    .DW    (p_datawidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (inclk),
    .rst_n     (inrst_n),
    .push      (pipe[READ_LATENCY-1]),
    .push_data (in_rddata),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count)
  );

`ifdef RAM_BURST_READER_CHECKSUM_EN
  // Running sum of transferred words; cleared when a burst is accepted and held afterwards.
  always_ff @(posedge inclk or negedge inrst_n) begin
    if (!inrst_n) begin
      out_checksum <= '0;
    end else if (accept) begin
      out_checksum <= '0;
    end else if (pop) begin
      out_checksum <= out_checksum + out_data;
    end
  end
`endif

endmodule
